// File: rtl/image_uart_tx.sv
// Image transmitter: sends a 4-byte height/width header, then R,G,B per pixel,
// as 8N1 UART bytes, pulling pixels through a valid/ready handshake.
module image_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] height,
    input  logic [15:0] width,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        uart_out,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] LAST_CLK  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  STOP_BIT  = 4'd9;
    localparam logic [3:0]  LAST_DATA = 4'd8;
    localparam logic [2:0]  HDR_BYTES = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PIX_WAIT,
        SEND_R,
        SEND_G,
        SEND_B,
        DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] height_reg, height_next;
    logic [15:0] width_reg, width_next;
    logic [31:0] pix_total_reg, pix_total_next;
    logic [31:0] pix_cnt_reg, pix_cnt_next;
    logic [2:0]  hdr_cnt_reg, hdr_cnt_next;
    logic [7:0]  g_hold_reg, g_hold_next;
    logic [7:0]  b_hold_reg, b_hold_next;
    logic [7:0]  tx_byte_reg, tx_byte_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [15:0] clk_cnt_reg, clk_cnt_next;
    logic        line_reg, line_next;

    logic        sending;
    logic        bit_done;
    logic        byte_done;
    logic        load;
    logic [7:0]  load_byte;
    logic [31:0] pix_cnt_inc;
    logic [7:0]  hdr_byte [4];

    // Header bytes in wire order: height MSB, height LSB, width MSB, width LSB.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hdr
            if (gi < 2) begin : g_height
                assign hdr_byte[gi] = height_reg[15-8*gi -: 8];
            end else begin : g_width
                assign hdr_byte[gi] = width_reg[15-8*(gi-2) -: 8];
            end
        end
    endgenerate

    assign sending     = (state_reg == HDR) || (state_reg == SEND_R) ||
                         (state_reg == SEND_G) || (state_reg == SEND_B);
    assign bit_done    = (clk_cnt_reg == LAST_CLK);
    assign byte_done   = bit_done && (bit_cnt_reg == STOP_BIT);
    assign pix_cnt_inc = pix_cnt_reg + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            height_reg    <= '0;
            width_reg     <= '0;
            pix_total_reg <= '0;
            pix_cnt_reg   <= '0;
            hdr_cnt_reg   <= '0;
            g_hold_reg    <= '0;
            b_hold_reg    <= '0;
            tx_byte_reg   <= '0;
            bit_cnt_reg   <= '0;
            clk_cnt_reg   <= '0;
            line_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            height_reg    <= height_next;
            width_reg     <= width_next;
            pix_total_reg <= pix_total_next;
            pix_cnt_reg   <= pix_cnt_next;
            hdr_cnt_reg   <= hdr_cnt_next;
            g_hold_reg    <= g_hold_next;
            b_hold_reg    <= b_hold_next;
            tx_byte_reg   <= tx_byte_next;
            bit_cnt_reg   <= bit_cnt_next;
            clk_cnt_reg   <= clk_cnt_next;
            line_reg      <= line_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        height_next    = height_reg;
        width_next     = width_reg;
        pix_total_next = pix_total_reg;
        pix_cnt_next   = pix_cnt_reg;
        hdr_cnt_next   = hdr_cnt_reg;
        g_hold_next    = g_hold_reg;
        b_hold_next    = b_hold_reg;
        tx_byte_next   = tx_byte_reg;
        bit_cnt_next   = bit_cnt_reg;
        clk_cnt_next   = clk_cnt_reg;
        line_next      = line_reg;
        load           = 1'b0;
        load_byte      = tx_byte_reg;

        // Bit engine: bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
        if (sending) begin
            if (bit_done) begin
                clk_cnt_next = '0;
                if (bit_cnt_reg != STOP_BIT) begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    line_next    = (bit_cnt_reg == LAST_DATA) ? 1'b1
                                                              : tx_byte_reg[bit_cnt_reg[2:0]];
                end
            end else begin
                clk_cnt_next = clk_cnt_reg + 16'd1;
            end
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    height_next    = height;
                    width_next     = width;
                    pix_total_next = {16'd0, height} * {16'd0, width};
                    pix_cnt_next   = '0;
                    hdr_cnt_next   = '0;
                    // Pose as the last cycle of a stop bit so the first header
                    // byte loads on the next edge through the normal path.
                    bit_cnt_next   = STOP_BIT;
                    clk_cnt_next   = LAST_CLK;
                    line_next      = 1'b1;
                    state_next     = HDR;
                end
            end
            HDR: begin
                if (byte_done) begin
                    if (hdr_cnt_reg == HDR_BYTES) begin
                        state_next = (pix_total_reg == 32'd0) ? DONE : PIX_WAIT;
                    end else begin
                        load         = 1'b1;
                        load_byte    = hdr_byte[hdr_cnt_reg[1:0]];
                        hdr_cnt_next = hdr_cnt_reg + 3'd1;
                    end
                end
            end
            PIX_WAIT: begin
                if (pix_valid) begin
                    g_hold_next = pix_g;
                    b_hold_next = pix_b;
                    load        = 1'b1;
                    load_byte   = pix_r;
                    state_next  = SEND_R;
                end
            end
            SEND_R: begin
                if (byte_done) begin
                    load       = 1'b1;
                    load_byte  = g_hold_reg;
                    state_next = SEND_G;
                end
            end
            SEND_G: begin
                if (byte_done) begin
                    load       = 1'b1;
                    load_byte  = b_hold_reg;
                    state_next = SEND_B;
                end
            end
            SEND_B: begin
                if (byte_done) begin
                    pix_cnt_next = pix_cnt_inc;
                    state_next   = (pix_cnt_inc == pix_total_reg) ? DONE : PIX_WAIT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Loading a byte drives its start bit on the very next cycle.
        if (load) begin
            tx_byte_next = load_byte;
            bit_cnt_next = '0;
            clk_cnt_next = '0;
            line_next    = 1'b0;
        end
    end

    assign uart_out  = line_reg;
    assign busy      = (state_reg != IDLE) && (state_reg != DONE);
    assign pix_ready = (state_reg == PIX_WAIT);
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_image_uart_tx.sv
// Directed bench for image_uart_tx: decodes the UART line, feeds pixels and
// checks bytes, timing, handshakes and reset behaviour with immediate assertions.
`timescale 1ns/1ps
module tb_image_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] height = 16'd0;
    logic [15:0] width = 16'd0;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic        pix_valid;
    logic        pix_ready, uart_out, busy, done;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    int frame_err = 0;
    int done_cnt = 0, done_cyc = 0, ready_cnt = 0, line_err = 0, busy_err = 0;

    logic        src_en = 1'b0;
    logic        stall_mode = 1'b0;
    int          src_n = 0;
    logic [23:0] src_pix [16];
    int          src_idx = 0;
    int          hs_count = 0;

    image_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .height    (height),
        .width     (width),
        .pix_r     (pix_r),
        .pix_g     (pix_g),
        .pix_b     (pix_b),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .uart_out  (uart_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Status flags sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy !== 1'b0) busy_err++;
        end
        if (pix_ready === 1'b1) begin
            ready_cnt++;
            if (uart_out !== 1'b1) line_err++;
        end
    end

    // UART decoder: samples each bit one cycle into it.
    initial begin
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge clk);
            if (uart_out === 1'b0) begin
                t0 = cyc;
                for (int k = 0; k < 8; k++) begin
                    repeat ((k == 0) ? CPB + 1 : CPB) @(negedge clk);
                    b[k] = uart_out;
                end
                repeat (CPB) @(negedge clk);
                if (uart_out !== 1'b1) frame_err++;
                rx_q.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    // Pixel source; drives garbage on the colour bytes whenever not valid.
    initial begin
        logic hs;
        pix_valid = 1'b0;
        pix_r = 8'd0;
        pix_g = 8'd0;
        pix_b = 8'd0;
        forever begin
            @(negedge clk);
            hs = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                src_idx++;
                hs_count++;
            end
            if (!src_en) src_idx = 0;
            if (src_en && src_idx < src_n && (!stall_mode || $urandom_range(0, 2) != 0)) begin
                pix_valid = 1'b1;
                {pix_r, pix_g, pix_b} = src_pix[src_idx];
            end else begin
                pix_valid = 1'b0;
                pix_r = 8'($urandom_range(0, 255));
                pix_g = 8'($urandom_range(0, 255));
                pix_b = 8'($urandom_range(0, 255));
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int first, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            v = {v[55:0], (first + i < rx_q.size()) ? rx_q[first + i] : 8'hxx};
        return v;
    endfunction

    task automatic do_start(input logic [15:0] h, input logic [15:0] w);
        @(posedge clk);
        #1;
        height = h;
        width = w;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < max_cyc) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("done_pulse", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int base, d0, r0, h0, k;
        logic [15:0] ph, pw;

        // Reset state
        #12;
        chk("rst_uart_out", 64'(uart_out), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pix_ready", 64'(pix_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);

        // Reset mid-byte: header byte 0 is 0x00 so the line is low here
        do_start(16'h0000, 16'h0005);
        repeat (10) @(posedge clk);
        #1;
        chk("midbyte_line_low", 64'(uart_out), 64'd0);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        chk("async_rst_uart_out", 64'(uart_out), 64'd1);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_pix_ready", 64'(pix_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (60) @(posedge clk);
        base = rx_q.size();
        repeat (50) @(posedge clk);
        #1;
        chk("no_bytes_after_reset", 64'(rx_q.size()), 64'(base));
        chk("no_done_after_reset", 64'(done_cnt), 64'(d0));

        // Header only, 0 x 5
        base = rx_q.size();
        r0 = ready_cnt;
        @(posedge clk);
        #1;
        height = 16'h0000;
        width = 16'h0005;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_line_idle", 64'(uart_out), 64'd1);
        @(posedge clk);
        #1;
        chk("first_start_bit", 64'(uart_out), 64'd0);
        wait_done(400);
        chk("hdr_only_count", 64'(rx_q.size() - base), 64'd4);
        chk("hdr_only_bytes", pack(base, 4), 64'h0000_0005);
        chk("hdr_only_done_time", 64'(done_cyc - rx_t[base]), 64'd160);
        chk("hdr_only_no_ready", 64'(ready_cnt - r0), 64'd0);
        chk("hdr_only_busy_low", 64'(busy), 64'd0);

        // Single pixel, valid held high
        src_pix[0] = 24'hA53CFF;
        src_n = 1;
        stall_mode = 1'b0;
        src_en = 1'b1;
        repeat (3) @(posedge clk);
        base = rx_q.size();
        h0 = hs_count;
        do_start(16'd1, 16'd1);
        wait_done(600);
        chk("px1_count", 64'(rx_q.size() - base), 64'd7);
        chk("px1_bytes", pack(base, 7), 64'h0000_0100_01A5_3CFF);
        chk("px1_back_to_back", 64'(rx_t[base + 1] - rx_t[base]), 64'd40);
        chk("px1_gap_before_r", 64'(rx_t[base + 4] - rx_t[base + 3]), 64'd41);
        chk("px1_done_time", 64'(done_cyc - rx_t[base]), 64'd281);
        chk("px1_handshakes", 64'(hs_count - h0), 64'd1);
        src_en = 1'b0;
        repeat (5) @(posedge clk);

        // 2 x 3 with random stalls; a mid-frame start with height 9 is ignored
        src_pix[0] = 24'h102030;
        src_pix[1] = 24'h405060;
        src_pix[2] = 24'h708090;
        src_pix[3] = 24'hA0B0C0;
        src_pix[4] = 24'hD0E0F0;
        src_pix[5] = 24'h0F1E2D;
        src_n = 6;
        stall_mode = 1'b1;
        src_en = 1'b1;
        base = rx_q.size();
        h0 = hs_count;
        r0 = line_err;
        do_start(16'd2, 16'd3);
        repeat (300) @(posedge clk);
        #1;
        height = 16'd9;
        width = 16'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_mid_frame", 64'(busy), 64'd1);
        wait_done(4000);
        chk("f23_count", 64'(rx_q.size() - base), 64'd22);
        chk("f23_header", pack(base, 4), 64'h0002_0003);
        chk("f23_pix0", pack(base + 4, 3), 64'h102030);
        chk("f23_pix1", pack(base + 7, 3), 64'h405060);
        chk("f23_pix2", pack(base + 10, 3), 64'h708090);
        chk("f23_pix3", pack(base + 13, 3), 64'hA0B0C0);
        chk("f23_pix4", pack(base + 16, 3), 64'hD0E0F0);
        chk("f23_pix5", pack(base + 19, 3), 64'h0F1E2D);
        chk("f23_handshakes", 64'(hs_count - h0), 64'd6);
        chk("f23_line_high_stall", 64'(line_err - r0), 64'd0);
        src_en = 1'b0;
        stall_mode = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("ignored_start_no_frame", 64'(rx_q.size() - base), 64'd22);

        // Abort during SEND_G
        src_pix[0] = 24'h112233;
        src_pix[1] = 24'h445566;
        src_n = 2;
        src_en = 1'b1;
        base = rx_q.size();
        do_start(16'd1, 16'd2);
        k = 0;
        while (rx_q.size() < base + 5 && k < 400) begin
            @(posedge clk);
            k++;
        end
        repeat (8) @(posedge clk);
        #1;
        chk("abort_r_byte", pack(base + 4, 1), 64'h11);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        chk("abort_uart_out", 64'(uart_out), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        src_en = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt), 64'(d0));

        // Fresh frame after abort, parsed as the receive side would
        src_pix[0] = 24'hDEAD01;
        src_pix[1] = 24'hBEEF02;
        src_pix[2] = 24'hCAFE03;
        src_pix[3] = 24'h00FF80;
        src_n = 4;
        src_en = 1'b1;
        base = rx_q.size();
        do_start(16'd2, 16'd2);
        wait_done(2000);
        ph = pack(base, 2)[15:0];
        pw = pack(base + 2, 2)[15:0];
        chk("loop_height", 64'(ph), 64'd2);
        chk("loop_width", 64'(pw), 64'd2);
        chk("loop_count", 64'(rx_q.size() - base), 64'd16);
        chk("loop_pix0", pack(base + 4, 3), 64'hDEAD01);
        chk("loop_pix1", pack(base + 7, 3), 64'hBEEF02);
        chk("loop_pix2", pack(base + 10, 3), 64'hCAFE03);
        chk("loop_pix3", pack(base + 13, 3), 64'h00FF80);
        src_en = 1'b0;

        chk("stop_bits_high", 64'(frame_err), 64'd0);
        chk("busy_low_with_done", 64'(busy_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
